// File: rtl/elevator_clkgen.sv
// elevator_clkgen: programmable-duty clock generator, free-run or one-shot.
// Ports: clk, rst (async, active-high), en, load, high_cnt, low_cnt,
//   oneshot, start -> clock, rise_tick, fall_tick, busy, done.
// Build option: define ELEVATOR_CLKGEN_ONESHOT_EN to enable one-shot mode.
module elevator_clkgen #(
  parameter int CNT_W    = 32,
  parameter int HIGH_DEF = 16,
  parameter int LOW_DEF  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] high_cnt,
  input  logic [CNT_W-1:0] low_cnt,
  input  logic             oneshot,
  input  logic             start,
  output logic             clock,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  localparam logic [CNT_W-1:0] HI_RST = CNT_W'(HIGH_DEF);
  localparam logic [CNT_W-1:0] LO_RST = CNT_W'(LOW_DEF);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  // Counter value loaded at phase entry; the phase ends when it hits 0.
  // A zero length maps to 0 as well, i.e. a one-cycle phase.
  function automatic logic [CNT_W-1:0] last_idx(
    input logic [CNT_W-1:0] len
  );
    return (len == '0) ? '0 : len - ONE;
  endfunction

  logic             os_sel;
  logic             os_go;

`ifdef ELEVATOR_CLKGEN_ONESHOT_EN
  assign os_sel = oneshot;
  assign os_go  = oneshot & start;
`else
  logic unused_os;
  assign os_sel    = 1'b0;
  assign os_go     = 1'b0;
  assign unused_os = oneshot ^ start;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_len_q, hi_len_d;
  logic [CNT_W-1:0] lo_len_q, lo_len_d;
  logic [CNT_W-1:0] hi_pend_q, hi_pend_d;
  logic [CNT_W-1:0] lo_pend_q, lo_pend_d;
  logic             os_q, os_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             done_q, done_d;
  logic             period_start;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_len_d     = hi_len_q;
    lo_len_d     = lo_len_q;
    hi_pend_d    = hi_pend_q;
    lo_pend_d    = lo_pend_q;
    os_d         = os_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    done_d       = 1'b0;
    period_start = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (os_sel ? os_go : en) begin
          period_start = 1'b1;
          os_d         = os_sel;
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_LOW;
          cnt_d   = last_idx(lo_len_q);
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_LOW: begin
        if (cnt_q == '0) begin
          // A one-shot period never chains; free-run chains on en.
          if (!os_q && en && !os_sel) begin
            period_start = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = os_q;
            os_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        os_d    = 1'b0;
      end
    endcase

    // Pending lengths become active only at a period boundary.
    if (period_start) begin
      state_d  = S_HIGH;
      hi_len_d = hi_pend_q;
      lo_len_d = lo_pend_q;
      cnt_d    = last_idx(hi_pend_q);
      rise_d   = 1'b1;
    end

    if (load) begin
      hi_pend_d = high_cnt;
      lo_pend_d = low_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_len_q  <= HI_RST;
      lo_len_q  <= LO_RST;
      hi_pend_q <= HI_RST;
      lo_pend_q <= LO_RST;
      os_q      <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_len_q  <= hi_len_d;
      lo_len_q  <= lo_len_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
      os_q      <= os_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      done_q    <= done_d;
    end
  end

  assign clock     = (state_q == S_HIGH);
  assign busy      = (state_q != S_IDLE);
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
  assign done      = done_q;

endmodule

// File: tb/tb_elevator_clkgen.sv
// tb_elevator_clkgen: directed + random bench for elevator_clkgen.
// Reference model expands each period into a queue of phase cycles.
module tb_elevator_clkgen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [31:0] high_cnt = '0;
  logic [31:0] low_cnt = '0;
  logic        oneshot = 1'b0;
  logic        start = 1'b0;
  logic        clock, rise_tick, fall_tick, busy, done;

  int checks = 0;
  int errors = 0;

  // model: 1=first high, 2=high, 3=first low, 4=low
  int q[$];
  int pend_hi, pend_lo;
  bit m_busy, m_os;

  elevator_clkgen dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .high_cnt(high_cnt), .low_cnt(low_cnt),
    .oneshot(oneshot), .start(start),
    .clock(clock), .rise_tick(rise_tick),
    .fall_tick(fall_tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int eff(int x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic model_reset();
    q.delete();
    pend_hi = 16;
    pend_lo = 4;
    m_busy  = 0;
    m_os    = 0;
  endtask

  task automatic tick();
    int cur;
    bit dn, go, sel;
`ifdef ELEVATOR_CLKGEN_ONESHOT_EN
    sel = oneshot;
`else
    sel = 0;
`endif
    dn = 0;
    go = 0;
    if (q.size() != 0) begin
      cur = q.pop_front();
    end else begin
      if (m_busy) begin
        go = !m_os && en && !sel;
        dn = m_os;
      end else begin
        go = sel ? start : en;
      end
      if (go) begin
        m_os = !m_busy && sel;
        q.push_back(1);
        for (int i = 1; i < eff(pend_hi); i++) q.push_back(2);
        q.push_back(3);
        for (int i = 1; i < eff(pend_lo); i++) q.push_back(4);
        cur = q.pop_front();
      end else begin
        cur = 0;
        m_os = 0;
      end
    end
    if (load) begin
      pend_hi = int'(high_cnt);
      pend_lo = int'(low_cnt);
    end
    m_busy = (cur != 0);
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    chk("clock", 32'(clock), 32'(cur == 1 || cur == 2));
    chk("rise", 32'(rise_tick), 32'(cur == 1));
    chk("fall", 32'(fall_tick), 32'(cur == 3));
    chk("busy", 32'(busy), 32'(cur != 0));
    chk("done", 32'(done), 32'(dn));
  endtask

  task automatic wait_rise();
    for (int i = 0; i < 80 && rise_tick !== 1'b1; i++) tick();
    chk("wait_rise", 32'(rise_tick), 32'd1);
  endtask

  task automatic measure(string tag, int eh, int el);
    int h, l;
    h = 0;
    l = 0;
    while (clock === 1'b1 && h < 300) begin
      h++;
      tick();
    end
    while (clock === 1'b0 && busy === 1'b1 && l < 300) begin
      l++;
      tick();
    end
    chk({tag, "_hi"}, 32'(h), 32'(eh));
    chk({tag, "_lo"}, 32'(l), 32'(el));
  endtask

  task automatic do_load(int h, int l);
    load     = 1'b1;
    high_cnt = 32'(h);
    low_cnt  = 32'(l);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_clock", 32'(clock), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();

    // default free-run 16/4
    en = 1'b1;
    wait_rise();
    measure("def1", 16, 4);
    measure("def2", 16, 4);

    // load 3/2 in HIGH cycle 5
    repeat (4) tick();
    do_load(3, 2);
    measure("ld_cur", 12, 4);
    measure("ld_new", 3, 2);

    // zero lengths act as one cycle
    do_load(0, 0);
    measure("z_cur", 3, 2);
    measure("z1", 1, 1);
    measure("z2", 1, 1);

    // back to 16/4, then drop en in HIGH cycle 8
    do_load(16, 4);
    measure("z3", 1, 1);
    repeat (7) tick();
    en = 1'b0;
    measure("en_drop", 9, 4);
    chk("idle_clock", 32'(clock), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    repeat (3) tick();

    // async reset in LOW cycle 2 discards pending 5/5
    en = 1'b1;
    wait_rise();
    do_load(5, 5);
    repeat (17) tick();
    chk("low2_clock", 32'(clock), 32'd0);
    chk("low2_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_clock", 32'(clock), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rise", 32'(rise_tick), 32'd0);
    chk("arst_fall", 32'(fall_tick), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    #1;
    rst = 1'b0;
    model_reset();
    wait_rise();
    measure("post_rst", 16, 4);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      oneshot = ($urandom_range(0, 5) == 0);
      start   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0)
        do_load(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      tick();
    end
    en      = 1'b0;
    oneshot = 1'b0;
    repeat (40) tick();
    chk("rand_idle", 32'(busy), 32'd0);

`ifdef ELEVATOR_CLKGEN_ONESHOT_EN
    do_load(3, 2);
    tick();
    oneshot = 1'b1;
    start   = 1'b1;
    tick();
    measure("os", 3, 2);
    chk("os_done", 32'(done), 32'd1);
    en = 1'b1;
    tick();
    chk("os_done_clr", 32'(done), 32'd0);
    repeat (5) tick();
    chk("os_ign_en", 32'(busy), 32'd0);
`else
    oneshot = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b1;
    tick();
    chk("no_os_busy", 32'(busy), 32'd0);
    chk("no_os_done", 32'(done), 32'd0);
`endif
    oneshot = 1'b0;
    en      = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_clkgen.md
ELEVATOR_CLKGEN -- requirements
Module: elevator_clkgen

Interface
REQ-001 SHALL have parameter CNT_W, default 32, phase-counter and period-register width.
REQ-002 SHALL have parameter HIGH_DEF, default 16, reset value of the high-phase length in clk cycles.
REQ-003 SHALL have parameter LOW_DEF, default 4, reset value of the low-phase length in clk cycles.
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on its rising edge only.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  free-run enable (level).
REQ-007 SHALL have port load  input  1  one-cycle strobe capturing high_cnt/low_cnt.
REQ-008 SHALL have port high_cnt  input  CNT_W  requested high-phase length.
REQ-009 SHALL have port low_cnt  input  CNT_W  requested low-phase length.
REQ-010 SHALL have port oneshot  input  1  mode select, 1 = single period per start.
REQ-011 SHALL have port start  input  1  one-cycle one-shot trigger.
REQ-012 SHALL have port clock  output  1  registered generated clock.
REQ-013 SHALL have port rise_tick  output  1  one-cycle pulse in the first cycle clock is 1.
REQ-014 SHALL have port fall_tick  output  1  one-cycle pulse in the first cycle clock is 0 after a high phase.
REQ-015 SHALL have port busy  output  1  1 while in HIGH or LOW state.
REQ-016 SHALL have port done  output  1  one-cycle pulse when a one-shot period completes.

Function
REQ-017 SHALL implement states IDLE (clock=0), HIGH (clock=1) and LOW (clock=0); clock SHALL be decoded from registered state, glitch-free.
REQ-018 SHALL hold active lengths hi_len/lo_len; a length value of 0 SHALL be treated as 1.
REQ-019 SHALL stay in HIGH for exactly hi_len cycles and in LOW for exactly lo_len cycles; period = hi_len + lo_len cycles.
REQ-020 SHALL move IDLE->HIGH on the cycle after en is sampled 1 (free-run mode); LOW->HIGH at LOW end while en=1.
REQ-021 SHALL, when en drops, complete the current period and enter IDLE at LOW end; no truncated phase is permitted.
REQ-022 SHALL capture high_cnt/low_cnt into pending registers on load; pending values SHALL become active at the next period start (IDLE->HIGH or LOW->HIGH), never mid-period.
REQ-023 SHALL let the last load win when several loads occur in one period.
REQ-024 SHALL assert rise_tick on each HIGH entry and fall_tick on each LOW entry, each for exactly one cycle.
REQ-025 SHALL use a phase counter of CNT_W bits that reloads at every phase entry and never wraps.

Reset
REQ-026 SHALL, on rst=1, immediately force state=IDLE, clock=0, rise_tick=0, fall_tick=0, busy=0, done=0, counter=0.
REQ-027 SHALL reset active and pending lengths to HIGH_DEF/LOW_DEF; a reset mid-period SHALL discard that period.

Configuration
REQ-028 SHALL compile one-shot mode in when macro ELEVATOR_CLKGEN_ONESHOT_EN is defined.
REQ-029 SHALL, with the macro defined and oneshot=1, ignore en, run exactly one period on a start pulse sampled in IDLE, pulse done in the cycle after LOW ends, and ignore start while busy.
REQ-030 SHALL, without the macro, ignore oneshot and start, tie done to 0, and operate in free-run mode only.

Verification
REQ-031 SHALL verify: reset, en=1, default lengths -> clock high 16 cycles, low 4 cycles, rise_tick every 20 cycles, busy=1.
REQ-032 SHALL verify: load 3/2 in cycle 5 of HIGH -> current period stays 16/4; next period is 3 high / 2 low.
REQ-033 SHALL verify: en=0 in HIGH cycle 8 -> period completes at 16/4, then IDLE, clock=0, busy=0.
REQ-034 SHALL verify: load 0/0 -> clock toggles 1 high / 1 low cycle, period 2.
REQ-035 SHALL verify: rst pulse in LOW cycle 2 -> outputs 0 the same cycle; lengths revert to 16/4.
REQ-036 SHALL verify: with macro defined, oneshot=1, start with 3/2 loaded -> one 3/2 period, done pulses once, then IDLE.
